// File: rtl/mult_pkg.sv
// mult_pkg: shared types and encodings for the sequential multiplier.
//   state_t      - controller state (IDLE, RUN)
//   FUNC_*       - func bus encodings for operand loads and product reads
package mult_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [1:0] FUNC_LOAD_M  = 2'b00;
    localparam logic [1:0] FUNC_LOAD_Q  = 2'b01;
    localparam logic [1:0] FUNC_READ_LO = 2'b10;
    localparam logic [1:0] FUNC_READ_HI = 2'b11;

endpackage

// File: rtl/mult_step.sv
// mult_step: one combinational iteration of the shift-add multiplier.
//   N       operand width
//   c, a    N+1 bit accumulator {C,A}
//   qw      multiplier working register
//   q_1     Booth history bit
//   m       multiplicand
//   mode    0 unsigned shift-add, 1 signed radix-2 Booth
//   *_next  register values after the add/subtract and the one-bit shift
module mult_step #(
    parameter int N = 8
) (
    input  logic         c,
    input  logic [N-1:0] a,
    input  logic [N-1:0] qw,
    input  logic         q_1,
    input  logic [N-1:0] m,
    input  logic         mode,
    output logic         c_next,
    output logic [N-1:0] a_next,
    output logic [N-1:0] qw_next,
    output logic         q_1_next
);

    logic [N:0] acc;

    // In signed mode {C,A} is an N+1 bit two's-complement accumulator, so
    // A - M with A = 0, M = -2^(N-1) does not overflow and the corner case
    // -2^(N-1) * -2^(N-1) stays exact. C always equals A's sign after a shift.
    always_comb begin
        acc = {c, a};
        if (mode) begin
            case ({qw[0], q_1})
                2'b10:   acc = {c, a} - {m[N-1], m};
                2'b01:   acc = {c, a} + {m[N-1], m};
                default: acc = {c, a};
            endcase
        end else if (qw[0]) begin
            acc = {c, a} + {1'b0, m};
        end

        c_next   = mode ? acc[N] : 1'b0;
        a_next   = acc[N:1];
        qw_next  = {acc[0], qw[N-1:1]};
        q_1_next = qw[0];
    end

endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: multi-cycle shift-add multiplier on a shared tristate bus.
//   clock   system clock, rising edge
//   nReset  synchronous active-low reset
//   start   begin a multiply (IDLE only)
//   func    00 load M, 01 load Q, 10 read product low, 11 read product high
//   oe      1 = block drives data (read), 0 = block samples data (write)
//   sign    0 unsigned, 1 signed Booth; captured at the start edge
//   ready   high while idle
//   done    one-cycle pulse when a result lands
//   data    bidirectional operand/result bus
// Build option: MULT_EARLY_TERM_EN enables unsigned early termination when
// all remaining multiplier bits are zero.
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clock,
    input  logic         nReset,
    input  logic         start,
    input  logic [1:0]   func,
    input  logic         oe,
    input  logic         sign,
    output logic         ready,
    output logic         done,
    inout  logic [N-1:0] data
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_t         state;
    state_t         state_next;

    logic [N-1:0]   m_reg;
    logic [N-1:0]   q_reg;
    logic [N-1:0]   a_reg;
    logic [N-1:0]   qw_reg;
    logic           c_reg;
    logic           q1_reg;
    logic           mode_reg;
    logic [CW-1:0]  cnt;
    logic [2*N-1:0] p_reg;
    logic           done_reg;

    logic           go;
    logic           step;
    logic           finish;
    logic           ld_m;
    logic           ld_q;
    logic           early_hit;

    logic           c_nx;
    logic [N-1:0]   a_nx;
    logic [N-1:0]   qw_nx;
    logic           q1_nx;
    logic [2*N-1:0] p_next;

    mult_step #(.N(N)) u_step (
        .c        (c_reg),
        .a        (a_reg),
        .qw       (qw_reg),
        .q_1      (q1_reg),
        .m        (m_reg),
        .mode     (mode_reg),
        .c_next   (c_nx),
        .a_next   (a_nx),
        .qw_next  (qw_nx),
        .q_1_next (q1_nx)
    );

`ifdef MULT_EARLY_TERM_EN
    logic [N-1:0]   unproc_mask;
    logic [CW:0]    rem;
    logic [2*N-1:0] et_prod;

    // Low N-cnt bits of Qw are the multiplier bits not yet consumed; the
    // upper bits already hold product bits shifted in from A.
    // C is always zero between unsigned steps, so the one-edge shift by the
    // remaining count yields the final product directly.
    always_comb begin
        unproc_mask = {N{1'b1}} >> cnt;
        rem         = (CW+1)'(N) - {1'b0, cnt};
        et_prod     = (2*N)'({c_reg, a_reg, qw_reg} >> rem);
        early_hit   = !mode_reg && ((qw_reg & unproc_mask) == '0);
    end
`else
    assign early_hit = 1'b0;
`endif

    assign p_next = early_hit ? et_prod_sel() : {a_nx, qw_nx};

    function automatic logic [2*N-1:0] et_prod_sel();
`ifdef MULT_EARLY_TERM_EN
        return et_prod;
`else
        return '0;
`endif
    endfunction

    always_ff @(posedge clock) begin
        if (!nReset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        go         = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        ld_m       = 1'b0;
        ld_q       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    go         = 1'b1;
                    state_next = RUN;
                end else if (!oe) begin
                    ld_m = (func == FUNC_LOAD_M);
                    ld_q = (func == FUNC_LOAD_Q);
                end
            end
            RUN: begin
                step = 1'b1;
                if (early_hit || cnt == CW'(N-1)) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!nReset) begin
            m_reg    <= '0;
            q_reg    <= '0;
            a_reg    <= '0;
            qw_reg   <= '0;
            c_reg    <= 1'b0;
            q1_reg   <= 1'b0;
            mode_reg <= 1'b0;
            cnt      <= '0;
            p_reg    <= '0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= finish;
            if (ld_m) m_reg <= data;
            if (ld_q) q_reg <= data;
            if (go) begin
                a_reg    <= '0;
                qw_reg   <= q_reg;
                c_reg    <= 1'b0;
                q1_reg   <= 1'b0;
                cnt      <= '0;
                mode_reg <= sign;
            end
            if (step) begin
                a_reg  <= a_nx;
                qw_reg <= qw_nx;
                c_reg  <= c_nx;
                q1_reg <= q1_nx;
                cnt    <= cnt + 1'b1;
            end
            if (finish) p_reg <= p_next;
        end
    end

    assign ready = (state == IDLE);
    assign done  = done_reg;

    assign data = (state == IDLE && oe && func[1])
                ? (func[0] ? p_reg[2*N-1:N] : p_reg[N-1:0])
                : 'z;

endmodule

// File: tb/tb_seq_multiplier.sv
module tb_seq_multiplier;

    localparam int N = 8;

    logic         clock;
    logic         nReset;
    logic         start;
    logic [1:0]   func;
    logic         oe;
    logic         sign;
    logic         ready;
    logic         done;
    wire  [N-1:0] data;

    logic         tb_drive;
    logic [N-1:0] tb_val;

    int n_cmp;
    int n_err;

    assign data = tb_drive ? tb_val : 'z;

    seq_multiplier #(.N(N)) dut (
        .clock  (clock),
        .nReset (nReset),
        .start  (start),
        .func   (func),
        .oe     (oe),
        .sign   (sign),
        .ready  (ready),
        .done   (done),
        .data   (data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Undriven bus: z in 4-state simulators, 0 in 2-state ones.
    function automatic logic [N-1:0] bus_seen();
        return (^data === 1'bx) ? '0 : data;
    endfunction

    function automatic logic [2*N-1:0] ref_product(input logic [N-1:0] m,
                                                   input logic [N-1:0] q,
                                                   input logic sgn);
        int sm, sq;
        if (sgn) begin
            sm = (m >= 2**(N-1)) ? int'(m) - 2**N : int'(m);
            sq = (q >= 2**(N-1)) ? int'(q) - 2**N : int'(q);
        end else begin
            sm = int'(m);
            sq = int'(q);
        end
        return (2*N)'(sm * sq);
    endfunction

    // Cycles with ready low: N, or with early termination the first step
    // index at which no multiplier bits remain, plus one.
    function automatic int exp_cycles(input logic [N-1:0] q, input logic sgn);
        int k;
        k = 0;
`ifdef MULT_EARLY_TERM_EN
        if (!sgn) begin
            while (k < N && (q >> k) != 0) k++;
            return (k < N) ? k + 1 : N;
        end
`endif
        return N + k;
    endfunction

    task automatic load_ops(input logic [N-1:0] m, input logic [N-1:0] q);
        @(negedge clock);
        oe = 1'b0; tb_drive = 1'b1; func = 2'b00; tb_val = m;
        @(negedge clock);
        func = 2'b01; tb_val = q;
        @(negedge clock);
        oe = 1'b1; tb_drive = 1'b0; func = 2'b10;
    endtask

    task automatic read_p(output logic [2*N-1:0] p);
        @(negedge clock);
        oe = 1'b1; tb_drive = 1'b0; func = 2'b10;
        #1 p[N-1:0] = data;
        func = 2'b11;
        #1 p[2*N-1:N] = data;
    endtask

    task automatic start_op(input logic sgn);
        @(negedge clock);
        start = 1'b1; sign = sgn;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Called at the negedge after the start edge; returns ready-low cycles.
    task automatic wait_done(input string tag, output int cyc);
        logic early_done;
        early_done = 1'b0;
        cyc = 0;
        while (ready == 1'b0 && cyc < 40) begin
            if (done) early_done = 1'b1;
            cyc++;
            @(negedge clock);
        end
        check({tag, "_done_in_run"}, early_done, 1'b0);
        check({tag, "_done_pulse"}, done, 1'b1);
        @(negedge clock);
        check({tag, "_done_clear"}, done, 1'b0);
    endtask

    task automatic run_case(input string tag, input logic [N-1:0] m,
                            input logic [N-1:0] q, input logic sgn);
        int cyc;
        logic [2*N-1:0] p;
        load_ops(m, q);
        start_op(sgn);
        wait_done(tag, cyc);
        check({tag, "_cycles"}, cyc, exp_cycles(q, sgn));
        read_p(p);
        check({tag, "_prod"}, p, ref_product(m, q, sgn));
    endtask

    initial begin
        int cyc;
        logic [2*N-1:0] p;
        logic [N-1:0] rm, rq;
        logic rs;

        n_cmp = 0; n_err = 0;
        nReset = 1'b0; start = 1'b0; func = 2'b00; oe = 1'b1; sign = 1'b0;
        tb_drive = 1'b0; tb_val = '0;
        repeat (3) @(negedge clock);
        nReset = 1'b1;
        check("rst_ready", ready, 1'b1);
        check("rst_done", done, 1'b0);
        read_p(p);
        check("rst_prod", p, 16'h0000);

        run_case("u13x11", 8'd13, 8'd11, 1'b0);
        run_case("u255x255", 8'hFF, 8'hFF, 1'b0);
        run_case("sFDx07", 8'hFD, 8'h07, 1'b1);
        run_case("s80x80", 8'h80, 8'h80, 1'b1);
        run_case("u200x1", 8'd200, 8'd1, 1'b0);
        run_case("u200x0", 8'd200, 8'd0, 1'b0);
        run_case("s200x1", 8'd200, 8'd1, 1'b1);
        run_case("u1x80", 8'd1, 8'h80, 1'b0);

        // Idle read with func=0x leaves the bus floating (P = 0x0000 here
        // is useless, so establish a nonzero product first).
        run_case("u255x255b", 8'hFF, 8'hFF, 1'b0);
        @(negedge clock);
        oe = 1'b1; func = 2'b00;
        #1 check("idle_z_f00", bus_seen(), 8'h00);
        func = 2'b01;
        #1 check("idle_z_f01", bus_seen(), 8'h00);

        // Loads and start during RUN are ignored; the bus floats.
        load_ops(8'd13, 8'd11);
        start_op(1'b0);
        check("intf_c1_ready", ready, 1'b0);
        oe = 1'b0; tb_drive = 1'b1; func = 2'b00; tb_val = 8'h55; start = 1'b1;
        @(negedge clock);
        start = 1'b0; oe = 1'b1; tb_drive = 1'b0; func = 2'b10;
        #1 check("intf_z_lo", bus_seen(), 8'h00);
        func = 2'b11;
        #1 check("intf_z_hi", bus_seen(), 8'h00);
        wait_done("intf", cyc);
        check("intf_cycles", cyc + 1, exp_cycles(8'd11, 1'b0));
        check("intf_no_restart", ready, 1'b1);
        read_p(p);
        check("intf_prod", p, 16'h008F);

        // Reset at the third RUN edge aborts and clears the product.
        load_ops(8'h12, 8'hB4);
        start_op(1'b0);
        @(negedge clock);
        @(negedge clock);
        nReset = 1'b0; start = 1'b1;
        @(negedge clock);
        nReset = 1'b1; start = 1'b0;
        check("rstrun_ready", ready, 1'b1);
        check("rstrun_done", done, 1'b0);
        read_p(p);
        check("rstrun_prod", p, 16'h0000);
        run_case("after_rst", 8'd37, 8'd9, 1'b0);

        // Start edge beats a same-edge load of Q.
        load_ops(8'h04, 8'h03);
        @(negedge clock);
        start = 1'b1; sign = 1'b0; oe = 1'b0; tb_drive = 1'b1; func = 2'b01; tb_val = 8'h02;
        @(negedge clock);
        start = 1'b0; oe = 1'b1; tb_drive = 1'b0; func = 2'b10;
        wait_done("stld", cyc);
        read_p(p);
        check("stld_prod", p, 16'h000C);
        start_op(1'b0);
        wait_done("stld2", cyc);
        read_p(p);
        check("stld_q_kept", p, 16'h000C);

        // start held across completion re-triggers on the first idle edge.
        load_ops(8'd3, 8'd5);
        @(negedge clock);
        start = 1'b1; sign = 1'b0;
        @(negedge clock);
        wait_done("held", cyc);
        check("held_retrig", ready, 1'b0);
        start = 1'b0;
        wait_done("held2", cyc);
        check("held2_cycles", cyc, exp_cycles(8'd5, 1'b0));
        read_p(p);
        check("held2_prod", p, 16'h000F);

        for (int i = 0; i < 24; i++) begin
            rm = N'($urandom);
            rq = N'($urandom);
            rs = 1'($urandom);
            if (i % 6 == 0) rq = N'($urandom_range(0, 3));
            if (i % 8 == 1) rm = 8'h80;
            run_case($sformatf("rnd%0d", i), rm, rq, rs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Sequential shift-add multiplier, N-bit operands, 2N-bit product, runtime-selectable unsigned or signed (two's-complement, radix-2 Booth) mode. Sits behind the shared bidirectional data bus and func/oe port protocol as the multi-cycle successor of the combinational multiplier. Adds a real start/ready handshake, a one-cycle done pulse and an optional early-termination path.

## Interface
- N, default 8: operand width; product is 2N bits.
- clock  in  1  system clock; all state changes on the rising edge.
- nReset  in  1  synchronous, active-low reset.
- start  in  1  already-debounced start request; sampled high for one edge.
- func  in  2  operation select: 00 load M, 01 load Q, 10 read product low, 11 read product high.
- oe  in  1  1 = block drives data (read), 0 = block samples data (write).
- sign  in  1  mode: 0 unsigned, 1 signed; sampled at the start edge only.
- ready  out  1  1 when idle, result valid, accepting loads and start.
- done  out  1  single-cycle pulse on the first cycle that ready returns high.
- data  inout  N  bidirectional operand and result bus.

## Operation
- States: IDLE, RUN.
- IDLE, oe=0, func=00: M <= data; func=01: Q <= data; func=1x: no write.
- IDLE, oe=1, func=10/11: data = P[N-1:0] / P[2N-1:N]; func=0x: data = Z.
- RUN: data = Z regardless of oe/func; loads ignored; start ignored.
- Start edge (IDLE, start=1): A <= 0, Qw <= Q, q_1 <= 0, C <= 0, cnt <= 0, mode <= sign, state <= RUN. Any load in the same edge is ignored; operands are the pre-edge M and Q.
- Unsigned step: if Qw[0], {C,A} = A + M (N+1 bits); then {C,A,Qw} shifts right logically by one.
- Signed step: {Qw[0],q_1} = 10 → A -= M; 01 → A += M; else no change; then {A,Qw,q_1} shifts right arithmetically by one (A MSB replicated).
- Each RUN edge performs one step, cnt++; the step with cnt = N-1 sets state <= IDLE, P <= {A,Qw}, done <= 1.
- P keeps its value until the next completion or reset; a read during the next RUN is Z.
- Width rule: signed result exact for all inputs, including -2^(N-1) × -2^(N-1) = 2^(2N-2).

## Timing
- Reset (nReset=0 at an edge): state IDLE, M, Q, A, Qw, C, q_1, cnt, P = 0; ready = 1, done = 0; data = Z unless IDLE read. Reset mid-RUN aborts; P reads 0.
- Latency: ready low for exactly N cycles after the start edge (without early termination); done high in cycle N+1 only.
- ready is a registered function of state (ready = state==IDLE).
- start held high across completion: it re-triggers at the first IDLE edge; done is still asserted for that cycle.
- start asserted while nReset=0: reset wins.

## Configuration
- MULT_EARLY_TERM_EN defined: in unsigned mode, at any RUN edge where Qw (all unprocessed multiplier bits) is zero, the block shifts {C,A,Qw} right by the remaining count N-cnt in one edge and completes. Q=0 takes 1 cycle; Q=1 takes 2 cycles. Signed mode is unaffected and always takes N cycles.
- Not defined: no zero detect and no variable shifter; every operation takes N cycles.

## Structure
- Package mult_pkg: state enum (IDLE, RUN); func encodings FUNC_LOAD_M=2'b00, FUNC_LOAD_Q=2'b01, FUNC_READ_LO=2'b10, FUNC_READ_HI=2'b11.
- Sub-module mult_step: combinational, parameter N; inputs A, Qw, q_1, M, mode; outputs next C/A/Qw/q_1 for one step. The top holds registers, FSM, counter and bus tristate.

## Test plan
- N=8 unsigned, M=13, Q=11, start → ready low exactly 8 cycles, done pulse once; read lo=0x8F, hi=0x00.
- Unsigned 255×255 → lo=0x01, hi=0xFE. Signed 0xFD×0x07 → lo=0xEB, hi=0xFF. Signed 0x80×0x80 → lo=0x00, hi=0x40.
- With MULT_EARLY_TERM_EN: unsigned M=200, Q=1 → ready low 2 cycles, P=0x00C8. Q=0 → 1 cycle, P=0. Signed Q=1 → 8 cycles. Without the macro → all 8 cycles.
- During RUN drive oe=0, func=00, data=0x55 and pulse start → result unchanged, no restart; with oe=1, data is Z.
- nReset=0 at the 3rd RUN edge → next cycle ready=1, done=0; reads of lo/hi = 0x00; a new start then computes correctly.
- start and a load of Q=0x02 on the same edge (old Q=0x03, M=0x04) → product 0x000C; Q afterwards = 0x03.
